// File: rtl/char_gen_pkg.sv
// Shared types and constants for the operand-stream generator.
package char_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } state_e;

  // Data pattern selectors
  localparam logic [1:0] ModeTherm  = 2'd0;
  localparam logic [1:0] ModeLfsr   = 2'd1;
  localparam logic [1:0] ModeZero   = 2'd2;
  localparam logic [1:0] ModeToggle = 2'd3;

  localparam logic [31:0] LfsrPoly    = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'hACE1_2345;

  // One step of the Galois right-shift LFSR
  function automatic logic [31:0] lfsr_next(input logic [31:0] value);
    return (value >> 1) ^ (value[0] ? LfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/char_traffic_gen_if.sv
// Control, configuration and operand-stream signals of the generator.
interface char_traffic_gen_if #(
  parameter int unsigned N  = 24,
  parameter int unsigned CW = 16
);
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [CW-1:0] payload_len;
  logic [CW-1:0] gap_len;
  logic [CW-1:0] num_pkts;
  logic [31:0]   seed;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          op_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] pkt_cnt;
  logic [31:0]   active_cycles;

  // Generator side: sources the operand stream and status
  modport master (
    input  start, stop, mode, payload_len, gap_len, num_pkts, seed,
    output op_a, op_b, op_valid, busy, done, pkt_cnt, active_cycles
  );

  // Controller / consumer side
  modport slave (
    output start, stop, mode, payload_len, gap_len, num_pkts, seed,
    input  op_a, op_b, op_valid, busy, done, pkt_cnt, active_cycles
  );
endinterface

// File: rtl/char_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable.
module char_lfsr32
  import char_gen_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = DefaultSeed
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_enable,
  input  logic [31:0] i_seed,
  output logic [31:0] o_value
);

  logic [31:0] r_lfsr;

  // Load takes priority over stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_load) begin
      r_lfsr <= i_seed;
    end else if (i_enable) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/char_traffic_gen.sv
// Operand-stream generator: packets of flits separated by idle gaps, with
// selectable data pattern and active-cycle accounting.
module char_traffic_gen
  import char_gen_pkg::*;
#(
  parameter int unsigned N         = 24,
  parameter int unsigned CW        = 16,
  parameter logic [31:0] LFSR_SEED = DefaultSeed
) (
  input logic                clk,
  input logic                rst_n,
  char_traffic_gen_if.master bus
);

  localparam int unsigned WW = 2 * N;
  localparam int unsigned TW = $clog2(WW + 1);

  state_e        r_state, w_state_next;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_payload_len, r_gap_len, r_num_pkts;
  logic [CW-1:0] r_flit, r_gap_cnt, r_pkt_cnt;
  logic [TW-1:0] r_therm;
  logic [N-1:0]  r_op_a, r_op_b;
  logic          r_op_valid, r_done;
  logic [31:0]   r_active;

  logic          w_start_ok, w_empty, w_in_send;
  logic          w_last_flit, w_last_pkt, w_gap_end, w_flit_odd;
  logic [CW-1:0] w_pkt_inc;
  logic [WW-1:0] w_therm, w_word;
  logic [31:0]   w_lfsr, w_seed;

  assign w_start_ok  = (r_state == StIdle) && bus.start && !bus.stop;
  assign w_empty     = (bus.payload_len == '0) || (bus.num_pkts == '0);
  assign w_in_send   = (r_state == StSend);
  assign w_last_flit = (r_flit == r_payload_len - CW'(1));
  assign w_pkt_inc   = r_pkt_cnt + CW'(1);
  assign w_last_pkt  = (w_pkt_inc == r_num_pkts);
  assign w_gap_end   = (r_gap_cnt == r_gap_len - CW'(1));
  assign w_flit_odd  = r_flit[0];
  assign w_seed      = (bus.seed == 32'h0) ? LFSR_SEED : bus.seed;

  char_lfsr32 #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_start_ok),
    .i_enable (w_in_send),
    .i_seed   (w_seed),
    .o_value  (w_lfsr)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic; stop wins over packet sequencing but not over the flit itself
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start && !bus.stop) w_state_next = w_empty ? StDone : StSend;
      end
      StSend: begin
        if (bus.stop) begin
          w_state_next = StDone;
        end else if (w_last_flit) begin
          if (w_last_pkt)              w_state_next = StDone;
          else if (r_gap_len == '0)    w_state_next = StSend;
          else                         w_state_next = StGap;
        end
      end
      StGap: begin
        if (bus.stop)       w_state_next = StDone;
        else if (w_gap_end) w_state_next = StSend;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Run configuration captured when a run is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= ModeTherm;
      r_payload_len <= '0;
      r_gap_len     <= '0;
      r_num_pkts    <= '0;
    end else if (w_start_ok) begin
      r_mode        <= bus.mode;
      r_payload_len <= bus.payload_len;
      r_gap_len     <= bus.gap_len;
      r_num_pkts    <= bus.num_pkts;
    end
  end

  // Flit index and thermometer position; both restart every packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit  <= '0;
      r_therm <= '0;
    end else if (w_start_ok || (w_in_send && w_last_flit)) begin
      r_flit  <= '0;
      r_therm <= '0;
    end else if (w_in_send) begin
      r_flit  <= r_flit + CW'(1);
      r_therm <= (r_therm == TW'(WW)) ? '0 : r_therm + TW'(1);
    end
  end

  // Idle-gap cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_gap_cnt <= '0;
    else if (r_state == StGap)   r_gap_cnt <= r_gap_cnt + CW'(1);
    else                         r_gap_cnt <= '0;
  end

  // Packet and active-cycle accounting, cleared at run start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= '0;
      r_active  <= '0;
    end else if (w_start_ok) begin
      r_pkt_cnt <= '0;
      r_active  <= '0;
    end else if (w_in_send) begin
      if (w_last_flit)      r_pkt_cnt <= w_pkt_inc;
      if (r_active != '1)   r_active  <= r_active + 32'd1;
    end
  end

  // Thermometer code with r_therm ones in the low bits
  always_comb begin
    w_therm = '0;
    for (int i = 0; i < WW; i++) w_therm[i] = (TW'(i) < r_therm);
  end

  // Flit word for the current pattern
  always_comb begin
    w_word = '0;
    unique case (r_mode)
      ModeTherm:  w_word = w_flit_odd ? ~w_therm : w_therm;
      ModeLfsr:   w_word = {w_lfsr[31:32-N], w_lfsr[N-1:0]};
      ModeZero:   w_word = '0;
      ModeToggle: w_word = {WW{w_flit_odd}};
      default:    w_word = '0;
    endcase
  end

  // Operand registers hold outside SEND so the block under test sees no toggles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_op_valid <= w_in_send;
      r_done     <= (r_state == StDone);
      if (w_in_send) begin
        r_op_a <= w_word[N-1:0];
        r_op_b <= w_word[WW-1:N];
      end
    end
  end

  assign bus.op_a          = r_op_a;
  assign bus.op_b          = r_op_b;
  assign bus.op_valid      = r_op_valid;
  assign bus.busy          = (r_state != StIdle);
  assign bus.done          = r_done;
  assign bus.pkt_cnt       = r_pkt_cnt;
  assign bus.active_cycles = r_active;

endmodule
